// File: rtl/i2c_temp_responder.sv
// I2C target emulating the ADT7420 register map: address match, pointer register,
// coherent temperature snapshot on reads, writable config register at 0x03.
`timescale 1ns/1ps
module i2c_temp_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h4B,
  parameter logic [7:0] DEV_ID   = 8'hCB
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [12:0] temp_in,
  output logic [7:0]  config_reg,
  output logic        busy,
  output logic        addr_hit,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    IGNORE    = 4'd9
  } state_t;

  state_t      st;
  logic        scl_s1, scl_s2, scl_p;
  logic        sda_s1, sda_s2, sda_p;
  logic [2:0]  bit_cnt;
  logic [6:0]  shreg;
  logic [6:0]  tx_byte;
  logic [7:0]  pointer;
  logic [12:0] temp_snap;
  logic        rw;
  logic [1:0]  phase;

  logic        scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0]  rx_byte, next_byte;

  assign state = st;

  // Synchronizers plus one history stage; reset to the idle-high bus level.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_p <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_p <= 1'b1;
    end else begin
      scl_s1 <= scl_in; scl_s2 <= scl_s1; scl_p <= scl_s2;
      sda_s1 <= sda_in; sda_s2 <= sda_s1; sda_p <= sda_s2;
    end
  end

  assign scl_rise = scl_s2 & ~scl_p;
  assign scl_fall = ~scl_s2 & scl_p;
  assign start_ev = scl_s2 & scl_p & sda_p & ~sda_s2;
  assign stop_ev  = scl_s2 & scl_p & ~sda_p & sda_s2;
  assign rx_byte  = {shreg, sda_s2};

  function automatic logic [7:0] reg_read(input logic [7:0] p, input logic [12:0] t,
                                          input logic [7:0] cfg);
    case (p)
      8'h00:   reg_read = t[12:5];
      8'h01:   reg_read = {t[4:0], 3'b000};
      8'h02:   reg_read = 8'h00;
      8'h03:   reg_read = cfg;
      8'h0B:   reg_read = DEV_ID;
      default: reg_read = 8'h00;
    endcase
  endfunction

  assign next_byte = reg_read(pointer, temp_snap, config_reg);

  // Protocol FSM; STOP and START override every state.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      sda_oe     <= 1'b0;
      config_reg <= 8'h00;
      busy       <= 1'b0;
      addr_hit   <= 1'b0;
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      tx_byte    <= 7'd0;
      pointer    <= 8'h00;
      temp_snap  <= 13'd0;
      rw         <= 1'b0;
      phase      <= 2'd0;
    end else begin
      addr_hit <= 1'b0;
      if (stop_ev) begin
        st     <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        phase  <= 2'd0;
      end else if (start_ev) begin
        st      <= ADDR;
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
        phase   <= 2'd0;
      end else begin
        case (st)
          ADDR: if (scl_rise) begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                st   <= ADDR_ACK;
                rw   <= rx_byte[0];
                busy <= 1'b1;
              end else begin
                st <= IGNORE;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (phase == 2'd0) begin
              sda_oe   <= 1'b1;
              addr_hit <= 1'b1;
              phase    <= 2'd1;
              if (rw) temp_snap <= temp_in;
            end else begin
              phase   <= 2'd0;
              bit_cnt <= 3'd0;
              if (rw) begin
                st      <= RDATA;
                tx_byte <= next_byte[6:0];
                sda_oe  <= ~next_byte[7];
              end else begin
                st     <= PTR;
                sda_oe <= 1'b0;
              end
            end
          end
          PTR: if (scl_rise) begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              pointer <= rx_byte;
              st      <= PTR_ACK;
            end
          end
          PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (phase == 2'd0) begin
              sda_oe <= 1'b1;
              phase  <= 2'd1;
            end else begin
              sda_oe  <= 1'b0;
              phase   <= 2'd0;
              bit_cnt <= 3'd0;
              st      <= WDATA;
            end
          end
          WDATA: if (scl_rise) begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (pointer == 8'h03) config_reg <= rx_byte;
              pointer <= pointer + 8'd1;
              st      <= WDATA_ACK;
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                pointer <= pointer + 8'd1;
                phase   <= 2'd0;
                st      <= RDATA_ACK;
              end
            end else if (scl_fall) begin
              sda_oe  <= ~tx_byte[6];
              tx_byte <= {tx_byte[5:0], 1'b0};
            end
          end
          // Release SDA, sample the master's ACK, then present the next byte.
          RDATA_ACK: begin
            if (phase == 2'd0 && scl_fall) begin
              sda_oe <= 1'b0;
              phase  <= 2'd1;
            end else if (phase == 2'd1 && scl_rise) begin
              if (sda_s2) begin
                st    <= IGNORE;
                phase <= 2'd0;
              end else begin
                phase <= 2'd2;
              end
            end else if (phase == 2'd2 && scl_fall) begin
              st      <= RDATA;
              phase   <= 2'd0;
              bit_cnt <= 3'd0;
              tx_byte <= next_byte[6:0];
              sda_oe  <= ~next_byte[7];
            end
          end
          IDLE, IGNORE: ;
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule
